// File: rtl/tp_filt_pkg.sv
// Shared definitions for the Time Pilot filter scheduler:
// Q15 coefficients, select decoding and sequencer states.
package tp_filt_pkg;

    localparam int CYC_PER_CH = 5;

    localparam logic [1:0] FLT_BYPASS = 2'd0;
    localparam logic [1:0] FLT_LIGHT  = 2'd1;
    localparam logic [1:0] FLT_MEDIUM = 2'd2;
    localparam logic [1:0] FLT_HEAVY  = 2'd3;

    localparam logic signed [17:0] A2_LIGHT  = -18'sd31986;
    localparam logic signed [17:0] B_LIGHT   = 18'sd391;
    localparam logic signed [17:0] A2_MEDIUM = -18'sd32420;
    localparam logic signed [17:0] B_MEDIUM  = 18'sd174;
    localparam logic signed [17:0] A2_HEAVY  = -18'sd32622;
    localparam logic signed [17:0] B_HEAVY   = 18'sd73;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MAC0,
        S_MAC1,
        S_MAC2,
        S_WB,
        S_DONE
    } state_t;

    typedef struct packed {
        logic signed [17:0] a2;
        logic signed [17:0] b;
    } coef_t;

    // Bypass maps to zero coefficients; its MAC result is ignored.
    function automatic coef_t coef_of(input logic [1:0] sel);
        coef_t c;
        c = '{a2: '0, b: '0};
        case (sel)
            FLT_LIGHT:  c = '{a2: A2_LIGHT,  b: B_LIGHT};
            FLT_MEDIUM: c = '{a2: A2_MEDIUM, b: B_MEDIUM};
            FLT_HEAVY:  c = '{a2: A2_HEAVY,  b: B_HEAVY};
            default:    c = '{a2: '0, b: '0};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/tp_filt_mac.sv
// 18x16 signed multiplier with a 36-bit accumulator;
// y is the Q15 result (acc >>> 15, low 16 bits).
module tp_filt_mac (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               acc_en,
    input  logic               sub,
    input  logic signed [17:0] coef,
    input  logic signed [15:0] data,
    output logic signed [15:0] y
);

    logic signed [33:0] prod;
    logic signed [35:0] acc;

    assign prod = 34'(coef) * 34'(data);
    assign y    = acc[30:15];

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            acc <= '0;
        end else if (acc_en) begin
            acc <= sub ? acc - 36'(prod) : acc + 36'(prod);
        end
    end

endmodule

// File: rtl/tp_filter_sched.sv
// Time-shared 1st-order IIR low-pass across the six PSG channels.
// Define TP_FILT_MIX_EN to add the saturated mix_out port.
module tp_filter_sched
    import tp_filt_pkg::*;
#(
    parameter int NUM_CH = 6,
    parameter int DIV    = 220
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [16*NUM_CH-1:0]  in_ch,
    input  logic [2*NUM_CH-1:0]   flt_sel,
    output logic [16*NUM_CH-1:0]  out_ch,
    output logic                  out_valid,
    output logic                  busy
`ifdef TP_FILT_MIX_EN
    ,
    output logic signed [15:0]    mix_out
`endif
);

    localparam int CW  = $clog2(DIV);
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    if (NUM_CH * CYC_PER_CH + 1 >= DIV) begin : g_bad_div
        $error("tp_filter_sched: sequence does not fit in DIV");
    end

    state_t              state, nstate;
    logic [CW-1:0]       div_cnt;
    logic                tick;
    logic [CHW-1:0]      ch;
    logic                last;
    logic signed [15:0]  snap_x   [NUM_CH];
    logic [1:0]          snap_sel [NUM_CH];
    logic signed [15:0]  x1_rf    [NUM_CH];
    logic signed [15:0]  y1_rf    [NUM_CH];
    logic signed [15:0]  shadow   [NUM_CH];
    logic signed [15:0]  res      [NUM_CH];
    logic signed [15:0]  x_cur, x1_cur, y1_cur;
    logic signed [15:0]  y_new, mac_y, mac_data;
    logic signed [17:0]  mac_coef;
    logic                mac_clr, mac_en, mac_sub;
    logic                bypass;
    coef_t               coef;

    assign tick   = div_cnt == CW'(DIV - 1);
    assign last   = ch == CHW'(NUM_CH - 1);
    assign busy   = state != S_IDLE && state != S_DONE;
    assign x_cur  = snap_x[ch];
    assign x1_cur = x1_rf[ch];
    assign y1_cur = y1_rf[ch];
    assign coef   = coef_of(snap_sel[ch]);
    assign bypass = snap_sel[ch] == FLT_BYPASS;
    assign y_new  = bypass ? x_cur : mac_y;

    tp_filt_mac u_mac (
        .clk    (clk),
        .reset  (reset),
        .clr    (mac_clr),
        .acc_en (mac_en),
        .sub    (mac_sub),
        .coef   (mac_coef),
        .data   (mac_data),
        .y      (mac_y)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= nstate;
    end

    always_comb begin
        nstate   = state;
        mac_clr  = 1'b0;
        mac_en   = 1'b0;
        mac_sub  = 1'b0;
        mac_coef = coef.b;
        mac_data = x_cur;
        unique case (state)
            S_IDLE: if (tick) nstate = S_LOAD;
            S_LOAD: begin
                mac_clr = 1'b1;
                nstate  = S_MAC0;
            end
            S_MAC0: begin
                mac_en = 1'b1;
                nstate = S_MAC1;
            end
            S_MAC1: begin
                mac_en   = 1'b1;
                mac_data = x1_cur;
                nstate   = S_MAC2;
            end
            S_MAC2: begin
                mac_en   = 1'b1;
                mac_sub  = 1'b1;
                mac_coef = coef.a2;
                mac_data = y1_cur;
                nstate   = S_WB;
            end
            S_WB:   nstate = last ? S_DONE : S_LOAD;
            S_DONE: nstate = S_IDLE;
            default: nstate = S_IDLE;
        endcase
    end

    // Lanes as they will appear once the channel in WB is written back.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            res[i] = (CHW'(i) == ch) ? y_new : shadow[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt   <= '0;
            ch        <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                snap_x[i]   <= '0;
                snap_sel[i] <= '0;
                x1_rf[i]    <= '0;
                y1_rf[i]    <= '0;
                shadow[i]   <= '0;
            end
        end else begin
            div_cnt   <= tick ? '0 : div_cnt + 1'b1;
            out_valid <= 1'b0;
            if (tick) begin
                ch <= '0;
                for (int i = 0; i < NUM_CH; i++) begin
                    snap_x[i]   <= in_ch[16*i +: 16];
                    snap_sel[i] <= flt_sel[2*i +: 2];
                end
            end
            if (state == S_WB) begin
                x1_rf[ch]  <= x_cur;
                y1_rf[ch]  <= y_new;
                shadow[ch] <= y_new;
                if (last) begin
                    out_valid <= 1'b1;
                    for (int i = 0; i < NUM_CH; i++) begin
                        out_ch[16*i +: 16] <= res[i];
                    end
                end else begin
                    ch <= ch + 1'b1;
                end
            end
        end
    end

`ifdef TP_FILT_MIX_EN
    localparam int SW = 19;
    localparam logic signed [SW-1:0] SAT_HI = 32767;
    localparam logic signed [SW-1:0] SAT_LO = -32768;

    logic signed [SW-1:0] mix_sum, mix_shr;
    logic signed [15:0]   mix_sat;

    always_comb begin
        mix_sum = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            mix_sum = mix_sum + SW'(res[i]);
        end
        mix_shr = mix_sum >>> 2;
        if (mix_shr > SAT_HI)      mix_sat = 16'sh7fff;
        else if (mix_shr < SAT_LO) mix_sat = 16'sh8000;
        else                       mix_sat = mix_shr[15:0];
    end

    always_ff @(posedge clk) begin
        if (reset)                  mix_out <= '0;
        else if (state == S_WB && last) mix_out <= mix_sat;
    end
`endif

endmodule
